// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 holds the accepted request; the result is computed combinationally
// from stage 1 and registered into stage 2 (R0 and flags) when stage 1 advances.
// The carry flag is updated at that same moment, so chained ADD/SUB always see
// the carry of the preceding ADD/SUB/SLT in acceptance order, whatever the stalls.
module alu_pipe #(
  parameter int size = 8,
  parameter int n    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [n-1:0]    select,
  input  logic            use_carry,
  input  logic [size-1:0] R2,
  input  logic [size-1:0] R3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] R0,
  output logic            R0_carry,
  output logic            R0_zero,
  output logic            R0_neg,
  output logic            R0_ovf
);

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_NOT = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_OR  = 3'b100,
    OP_AND = 3'b101,
    OP_SLT = 3'b110,
    OP_XOR = 3'b111
  } op_t;

  logic            s1_valid;
  op_t             s1_op;
  logic            s1_uc;
  logic [size-1:0] s1_a;
  logic [size-1:0] s1_b;
  logic            s2_valid;
  logic            carry_flag;

  logic            s1_adv;
  logic            cin;
  logic [size:0]   sum;
  logic [size:0]   diff;
  logic [size-1:0] res;
  logic            c_out;
  logic            v_out;
  logic            upd;

  // Stage 1 moves on when it holds work and stage 2 is free or draining this edge.
  // Reset gates in_ready directly so it drops asynchronously with rst.
  always_comb begin
    s1_adv    = s1_valid && (!s2_valid || out_ready);
    in_ready  = !rst && (!s1_valid || s1_adv);
    out_valid = s2_valid;
  end

  // Result and flag computation from the stage-1 operands.
  always_comb begin
    res   = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    upd   = 1'b0;
    sum   = '0;
    diff  = '0;
    cin   = s1_uc & carry_flag;
    case (s1_op)
      OP_MOV: res = s1_b;
      OP_NOT: res = ~s1_a;
      OP_ADD: begin
        sum   = {1'b0, s1_a} + {1'b0, s1_b} + {{size{1'b0}}, cin};
        res   = sum[size-1:0];
        c_out = sum[size];
        v_out = (s1_a[size-1] == s1_b[size-1]) && (sum[size-1] != s1_a[size-1]);
        upd   = 1'b1;
      end
      OP_SUB: begin
        // Bit 'size' of the widened difference is set exactly when A < B + bin.
        diff  = {1'b0, s1_a} - {1'b0, s1_b} - {{size{1'b0}}, cin};
        res   = diff[size-1:0];
        c_out = diff[size];
        v_out = (s1_a[size-1] != s1_b[size-1]) && (diff[size-1] != s1_a[size-1]);
        upd   = 1'b1;
      end
      OP_OR:  res = s1_a | s1_b;
      OP_AND: res = s1_a & s1_b;
      OP_SLT: begin
        res   = {{(size-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
        c_out = (s1_a < s1_b);
        upd   = 1'b1;
      end
      OP_XOR: res = s1_a ^ s1_b;
      default: res = '0;
    endcase
  end

  // Stage 1: capture a request on handshake, otherwise empty when it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MOV;
      s1_uc    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_op    <= op_t'(select);
      s1_uc    <= use_carry;
      s1_a     <= R2;
      s1_b     <= R3;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: load the computed result when stage 1 advances, drop it when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      R0       <= '0;
      R0_carry <= 1'b0;
      R0_zero  <= 1'b0;
      R0_neg   <= 1'b0;
      R0_ovf   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      R0       <= res;
      R0_carry <= c_out;
      R0_zero  <= (res == '0);
      R0_neg   <= res[size-1];
      R0_ovf   <= v_out;
    end else if (s2_valid && out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Carry flag follows ADD/SUB/SLT results in the order they are computed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_flag <= 1'b0;
    end else if (s1_adv && upd) begin
      carry_flag <= c_out;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized stimulus for alu_pipe (size=8), checked
// every cycle against a queue-based behavioural model of the pipeline.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] select;
  logic       use_carry;
  logic [7:0] R2;
  logic [7:0] R3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] R0;
  logic       R0_carry;
  logic       R0_zero;
  logic       R0_neg;
  logic       R0_ovf;

  alu_pipe #(.size(8), .n(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .use_carry(use_carry),
    .R2(R2), .R3(R3),
    .out_valid(out_valid), .out_ready(out_ready),
    .R0(R0), .R0_carry(R0_carry), .R0_zero(R0_zero),
    .R0_neg(R0_neg), .R0_ovf(R0_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c, z, ng, v;
    int         acc;
    logic       pin;
    int         pr, pc, pz, pn, pv;
  } exp_t;

  exp_t q[$];
  logic mcf;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Literal expectations attached to the next accepted request (-1 = don't care).
  logic pin_en;
  int   pin_r, pin_c, pin_z, pin_n, pin_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_pin(input string nm, input logic act, input int exp);
    if (exp >= 0) chk(nm, 64'(act), 64'(exp));
  endtask

  function automatic int sgn(input logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  // Behavioural model: plain integer arithmetic on the architectural rules.
  task automatic model(input logic [2:0] op, input logic uc, input logic [7:0] a,
                       input logic [7:0] b, output exp_t e);
    int s, ss, cin;
    e.r = 8'h00; e.c = 1'b0; e.v = 1'b0;
    cin = (uc && mcf) ? 1 : 0;
    case (op)
      3'd0: e.r = b;
      3'd1: e.r = ~a;
      3'd2: begin
        s = int'(a) + int'(b) + cin;
        ss = sgn(a) + sgn(b) + cin;
        e.r = 8'(s & 255); e.c = (s > 255); e.v = (ss > 127) || (ss < -128);
        mcf = e.c;
      end
      3'd3: begin
        s = int'(a) - int'(b) - cin;
        ss = sgn(a) - sgn(b) - cin;
        e.r = 8'(s & 255); e.c = (s < 0); e.v = (ss > 127) || (ss < -128);
        mcf = e.c;
      end
      3'd4: e.r = a | b;
      3'd5: e.r = a & b;
      3'd6: begin
        e.r = (sgn(a) < sgn(b)) ? 8'd1 : 8'd0;
        e.c = (int'(a) < int'(b));
        mcf = e.c;
      end
      default: e.r = a ^ b;
    endcase
    e.z = (e.r == 8'h00);
    e.ng = e.r[7];
  endtask

  // Compare process: flow control, ordering, data and flags on every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_r0", 64'(R0), 64'd0);
      chk("rst_flags", 64'({R0_carry, R0_zero, R0_neg, R0_ovf}), 64'd0);
      q.delete();
      mcf = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      chk("out_valid", 64'(out_valid), 64'((q.size() > 0) && (cyc >= q[0].acc + 1)));
      if (out_valid && q.size() > 0) begin
        e = q[0];
        chk("r0", 64'(R0), 64'(e.r));
        chk("carry", 64'(R0_carry), 64'(e.c));
        chk("zero", 64'(R0_zero), 64'(e.z));
        chk("neg", 64'(R0_neg), 64'(e.ng));
        chk("ovf", 64'(R0_ovf), 64'(e.v));
        if (e.pin) begin
          chk_pin("pin_r0", 1'b0, -1);
          chk("pin_r0", 64'(R0), 64'(e.pr));
          chk_pin("pin_carry", R0_carry, e.pc);
          chk_pin("pin_zero", R0_zero, e.pz);
          chk_pin("pin_neg", R0_neg, e.pn);
          chk_pin("pin_ovf", R0_ovf, e.pv);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        model(select, use_carry, R2, R3, e);
        e.acc = cyc + 1;
        e.pin = pin_en;
        e.pr = pin_r; e.pc = pin_c; e.pz = pin_z; e.pn = pin_n; e.pv = pin_v;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic uc, input logic [7:0] a,
                      input logic [7:0] b, input int pr, input int pc, input int pz,
                      input int pn, input int pv);
    int k;
    k = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; select = op; use_carry = uc; R2 = a; R3 = b;
    pin_en = 1'b1; pin_r = pr; pin_c = pc; pin_z = pz; pin_n = pn; pin_v = pv;
    @(negedge clk);
    while (!in_ready) begin
      k++;
      if (k > 50) begin
        $display("FAIL send_timeout: in_ready stuck low, expected high within 50 cycles");
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; pin_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    $fatal(1);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] corners [4];
    corners[0] = 8'h00; corners[1] = 8'h7F; corners[2] = 8'h80; corners[3] = 8'hFF;
    if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [2:0] ops [5];
    int         pr5 [5];
    int         k, t;
    rst = 1'b1; in_valid = 1'b0; select = 3'd0; use_carry = 1'b0;
    R2 = 8'h00; R3 = 8'h00; out_ready = 1'b1;
    pin_en = 1'b0; pin_r = -1; pin_c = -1; pin_z = -1; pin_n = -1; pin_v = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Carry chain through ADD.
    send(3'd2, 1'b0, 8'hF0, 8'h20, 8'h10, 1, 0, 0, 0);
    send(3'd2, 1'b1, 8'h01, 8'h01, 8'h03, 0, 0, 0, 0);
    // SUB borrow and signed overflow.
    send(3'd3, 1'b0, 8'h05, 8'h07, 8'hFE, 1, 0, 1, 0);
    send(3'd3, 1'b0, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1);
    // SLT signed result versus unsigned carry.
    send(3'd6, 1'b0, 8'h80, 8'h01, 8'h01, 0, 0, 0, 0);
    send(3'd6, 1'b0, 8'h01, 8'h80, 8'h00, 1, 1, 0, 0);
    // SUB chained on the SLT carry: 0x10 - 0x01 - 1.
    send(3'd3, 1'b1, 8'h10, 8'h01, 8'h0E, 0, 0, 0, 0);
    drain();

    // Back-to-back requests with the consumer stalled for three cycles.
    ops[0] = 3'd1; ops[1] = 3'd2; ops[2] = 3'd3; ops[3] = 3'd4; ops[4] = 3'd5;
    pr5[0] = 8'hF3; pr5[1] = 8'h16; pr5[2] = 8'h02; pr5[3] = 8'h0E; pr5[4] = 8'h08;
    k = 0; t = 0;
    while (k < 5) begin
      @(posedge clk); #1;
      in_valid = 1'b1; select = ops[k]; use_carry = 1'b0; R2 = 8'h0C; R3 = 8'h0A;
      pin_en = 1'b1; pin_r = pr5[k]; pin_c = 0; pin_z = 0; pin_n = -1; pin_v = 0;
      out_ready = (t >= 3);
      @(negedge clk);
      if (in_ready) k++;
      t++;
      if (t > 50) begin
        $display("FAIL stall_timeout: accepted %0d of 5 requests", k);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; pin_en = 1'b0;
    drain();

    // Reset with both stages full, then a chained ADD must see a cleared carry.
    out_ready = 1'b0;
    send(3'd2, 1'b0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
    send(3'd2, 1'b0, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    send(3'd2, 1'b1, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0);
    drain();

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (i % 300 == 150) rst = 1'b1;
      else if (i % 300 == 152) rst = 1'b0;
      in_valid = ($urandom_range(3) != 0);
      select = 3'($urandom);
      use_carry = 1'($urandom);
      R2 = pick();
      R3 = pick();
      out_ready = ($urandom_range(2) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
